// File: rtl/usb_pkg.sv
// Shared USB-block constants and types.
package usb_pkg;

   localparam int unsigned BUFFER_DEPTH = 64;
   localparam int unsigned BYTE_WIDTH   = 8;
   localparam int unsigned OCC_WIDTH    = $clog2(BUFFER_DEPTH) + 1;

   typedef logic [BYTE_WIDTH-1:0] byte_t;

endpackage : usb_pkg

// File: rtl/data_buffer_if.sv
// Request/response bundle between the data buffer and its producers/consumers.
interface data_buffer_if
   import usb_pkg::*;
#(
   parameter int unsigned DEPTH = BUFFER_DEPTH,
   parameter int unsigned WIDTH = BYTE_WIDTH
);

   logic                     clear;
   logic                     store_tx_data;
   logic [WIDTH-1:0]         tx_data;
   logic                     store_rx_packet_data;
   logic [WIDTH-1:0]         rx_packet_data;
   logic                     get_tx_packet_data;
   logic                     get_rx_data;
   logic [WIDTH-1:0]         tx_packet_data;
   logic [WIDTH-1:0]         rx_data;
   logic [$clog2(DEPTH):0]   buffer_occupancy;
   logic                     buffer_error;

   // Producer/consumer side: issues stores, pops and clears.
   modport master (
      output clear, store_tx_data, tx_data, store_rx_packet_data, rx_packet_data,
             get_tx_packet_data, get_rx_data,
      input  tx_packet_data, rx_data, buffer_occupancy, buffer_error
   );

   // Buffer side.
   modport slave (
      input  clear, store_tx_data, tx_data, store_rx_packet_data, rx_packet_data,
             get_tx_packet_data, get_rx_data,
      output tx_packet_data, rx_data, buffer_occupancy, buffer_error
   );

endinterface : data_buffer_if

// File: rtl/data_buffer_mem.sv
// Register file: one synchronous write port, one asynchronous read port.
module data_buffer_mem
   import usb_pkg::*;
#(
   parameter int unsigned DEPTH = BUFFER_DEPTH,
   parameter int unsigned WIDTH = BYTE_WIDTH
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [WIDTH-1:0]           wdata,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [WIDTH-1:0]           rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage write; contents need no reset because occupancy gates the reads.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule : data_buffer_mem

// File: rtl/data_buffer.sv
// Shared single-packet byte FIFO between AHB, USB RX and USB TX.
module data_buffer
   import usb_pkg::*;
#(
   parameter int unsigned DEPTH = BUFFER_DEPTH,
   parameter int unsigned WIDTH = BYTE_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   data_buffer_if.slave  bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [OCC_W-1:0] occ;
   logic             err_q;

   logic             wr_req;
   logic             rd_req;
   logic             empty;
   logic             full;
   logic             do_wr;
   logic             do_rd;
   logic             err_c;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] head;

   // Arbitration: RX write beats TX write, TX pop beats AHB pop; flag every dropped/ignored request.
   always_comb begin
      wr_req  = 1'b0;
      rd_req  = 1'b0;
      empty   = 1'b0;
      full    = 1'b0;
      do_wr   = 1'b0;
      do_rd   = 1'b0;
      err_c   = 1'b0;
      wr_data = bus.tx_data;

      wr_req  = bus.store_rx_packet_data | bus.store_tx_data;
      rd_req  = bus.get_tx_packet_data | bus.get_rx_data;
      empty   = (occ == '0);
      full    = (occ == OCC_W'(DEPTH));
      if (bus.store_rx_packet_data) begin
         wr_data = bus.rx_packet_data;
      end

      // A pop at full frees the slot written in the same cycle.
      do_rd   = rd_req & ~empty;
      do_wr   = wr_req & (~full | do_rd);

      err_c   = (bus.store_rx_packet_data & bus.store_tx_data)
              | (bus.get_tx_packet_data & bus.get_rx_data)
              | (rd_req & empty)
              | (wr_req & ~do_wr);
   end

   // Pointer, occupancy and error state; clear overrides every request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         occ   <= '0;
         err_q <= 1'b0;
      end else if (bus.clear) begin
         wptr  <= '0;
         rptr  <= '0;
         occ   <= '0;
         err_q <= 1'b0;
      end else begin
         if (do_wr) begin
            wptr <= wptr + PTR_W'(1);
         end
         if (do_rd) begin
            rptr <= rptr + PTR_W'(1);
         end
         occ   <= occ + OCC_W'(do_wr) - OCC_W'(do_rd);
         err_q <= err_c;
      end
   end

   data_buffer_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_mem (
      .clk   (clk),
      .we    (do_wr & ~bus.clear),
      .waddr (wptr),
      .wdata (wr_data),
      .raddr (rptr),
      .rdata (head)
   );

   // Fall-through head byte, forced to zero when nothing is queued.
   assign bus.tx_packet_data   = (occ == '0) ? '0 : head;
   assign bus.rx_data          = (occ == '0) ? '0 : head;
   assign bus.buffer_occupancy = occ;
   assign bus.buffer_error     = err_q;

endmodule : data_buffer

// File: tb/tb_data_buffer.sv
// Scoreboard bench for data_buffer: directed stimulus, decoupled monitor.
module tb_data_buffer;
   import usb_pkg::*;

   typedef struct {
      int    cyc;
      int    occ;
      bit    err;
      byte_t head;
   } status_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   data_buffer_if bus ();

   data_buffer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int      cyc = 0;
   int      checks = 0;
   int      errors = 0;
   int      last_occ = 0;
   byte_t   last_head = 8'h00;
   status_t status_q[$];
   byte_t   pop_q[$];
   status_t mon_s;
   byte_t   mon_b;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endfunction

   // Monitor: compare popped bytes and per-cycle status against the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if ((bus.get_tx_packet_data || bus.get_rx_data) && bus.buffer_occupancy != 0) begin
            if (pop_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_unexpected @cycle %0d: got 0x%0h expected no pop",
                        cyc, bus.tx_packet_data);
            end else begin
               mon_b = pop_q.pop_front();
               if (bus.get_tx_packet_data)
                  check("pop_tx_data", int'(bus.tx_packet_data), int'(mon_b));
               else
                  check("pop_rx_data", int'(bus.rx_data), int'(mon_b));
            end
         end
         while (status_q.size() > 0 && status_q[0].cyc <= cyc) begin
            mon_s = status_q.pop_front();
            check("occupancy", int'(bus.buffer_occupancy), mon_s.occ);
            check("buffer_error", int'(bus.buffer_error), int'(mon_s.err));
            check("tx_head", int'(bus.tx_packet_data), int'(mon_s.head));
            check("rx_head", int'(bus.rx_data), int'(mon_s.head));
         end
      end
   end

   // One clock of stimulus plus the expected status after the edge that consumes it.
   task automatic step(input bit s_tx, input byte_t td, input bit s_rx, input byte_t rd,
                       input bit g_tx, input bit g_rx, input bit clr,
                       input int e_occ, input bit e_err, input byte_t e_head);
      status_t s;
      @(posedge clk);
      #1;
      bus.store_tx_data        = s_tx;
      bus.tx_data              = td;
      bus.store_rx_packet_data = s_rx;
      bus.rx_packet_data       = rd;
      bus.get_tx_packet_data   = g_tx;
      bus.get_rx_data          = g_rx;
      bus.clear                = clr;
      if ((g_tx || g_rx) && last_occ > 0) pop_q.push_back(last_head);
      s.cyc  = cyc + 1;
      s.occ  = e_occ;
      s.err  = e_err;
      s.head = e_head;
      status_q.push_back(s);
      last_occ  = e_occ;
      last_head = e_head;
   endtask

   task automatic idle(input int e_occ, input byte_t e_head);
      step(0, 8'h00, 0, 8'h00, 0, 0, 0, e_occ, 0, e_head);
   endtask

   initial begin
      #100000;
      errors++;
      $display("FAIL timeout: got no finish expected finish before 100000ns");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      bus.clear = 0; bus.store_tx_data = 0; bus.tx_data = 0;
      bus.store_rx_packet_data = 0; bus.rx_packet_data = 0;
      bus.get_tx_packet_data = 0; bus.get_rx_data = 0;
      #1;
      check("reset_occupancy", int'(bus.buffer_occupancy), 0);
      check("reset_error", int'(bus.buffer_error), 0);
      check("reset_tx_data", int'(bus.tx_packet_data), 0);
      check("reset_rx_data", int'(bus.rx_data), 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 0;

      // Single byte in and out.
      step(1, 8'hA5, 0, 8'h00, 0, 0, 0, 1, 0, 8'hA5);
      step(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00);
      idle(0, 8'h00);

      // Fill to 64, overflow store, back-to-back drain.
      for (int i = 0; i < 64; i++) step(1, 8'(i), 0, 8'h00, 0, 0, 0, i + 1, 0, 8'h00);
      step(1, 8'hFF, 0, 8'h00, 0, 0, 0, 64, 1, 8'h00);
      idle(64, 8'h00);
      for (int i = 0; i < 64; i++)
         step(0, 8'h00, 0, 8'h00, 1, 0, 0, 63 - i, 0, (i < 63) ? 8'(i + 1) : 8'h00);
      idle(0, 8'h00);

      // Pointer wrap: 60 in, 60 out, then 10 across 63->0.
      for (int i = 0; i < 60; i++) step(1, 8'(i + 'h40), 0, 8'h00, 0, 0, 0, i + 1, 0, 8'h40);
      for (int i = 0; i < 60; i++)
         step(0, 8'h00, 0, 8'h00, 1, 0, 0, 59 - i, 0, (i < 59) ? 8'(i + 'h41) : 8'h00);
      for (int i = 0; i < 10; i++) step(1, 8'(i + 'h80), 0, 8'h00, 0, 0, 0, i + 1, 0, 8'h80);
      for (int i = 0; i < 10; i++)
         step(0, 8'h00, 0, 8'h00, 1, 0, 0, 9 - i, 0, (i < 9) ? 8'(i + 'h81) : 8'h00);
      idle(0, 8'h00);

      // Write plus pop at full: no error, RX byte ends up last.
      for (int i = 0; i < 64; i++) step(1, 8'(i), 0, 8'h00, 0, 0, 0, i + 1, 0, 8'h00);
      step(0, 8'h00, 1, 8'h3C, 1, 0, 0, 64, 0, 8'h01);
      for (int i = 0; i < 64; i++)
         step(0, 8'h00, 0, 8'h00, 1, 0, 0, 63 - i, 0,
              (i < 62) ? 8'(i + 2) : ((i == 62) ? 8'h3C : 8'h00));
      idle(0, 8'h00);

      // Write collision, pop on empty, pop collision, write+pop on empty.
      step(1, 8'h11, 1, 8'h22, 0, 0, 0, 1, 1, 8'h22);
      step(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00);
      step(0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1, 8'h00);
      idle(0, 8'h00);
      step(1, 8'h61, 0, 8'h00, 0, 0, 0, 1, 0, 8'h61);
      step(1, 8'h62, 0, 8'h00, 0, 0, 0, 2, 0, 8'h61);
      step(0, 8'h00, 0, 8'h00, 1, 1, 0, 1, 1, 8'h62);
      step(0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
      step(1, 8'h5A, 0, 8'h00, 1, 0, 0, 1, 1, 8'h5A);
      step(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00);
      idle(0, 8'h00);

      // Clear beats a concurrent store.
      for (int i = 0; i < 20; i++) step(1, 8'(i + 'h10), 0, 8'h00, 0, 0, 0, i + 1, 0, 8'h10);
      step(1, 8'h77, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00);
      idle(0, 8'h00);

      // Asynchronous reset in the middle of a drain.
      for (int i = 0; i < 5; i++) step(1, 8'(i + 'h50), 0, 8'h00, 0, 0, 0, i + 1, 0, 8'h50);
      step(0, 8'h00, 0, 8'h00, 1, 0, 0, 4, 0, 8'h51);
      step(0, 8'h00, 0, 8'h00, 1, 0, 0, 3, 0, 8'h52);
      @(posedge clk);
      #1;
      status_q.delete();
      bus.get_tx_packet_data = 0;
      rst = 1;
      #1;
      check("midrst_occupancy", int'(bus.buffer_occupancy), 0);
      check("midrst_error", int'(bus.buffer_error), 0);
      check("midrst_tx_data", int'(bus.tx_packet_data), 0);
      check("midrst_rx_data", int'(bus.rx_data), 0);
      @(negedge clk) rst = 0;
      last_occ  = 0;
      last_head = 8'h00;
      idle(0, 8'h00);
      step(1, 8'h9E, 0, 8'h00, 0, 0, 0, 1, 0, 8'h9E);
      idle(1, 8'h9E);

      repeat (3) @(negedge clk);
      #1;
      check("status_queue_drained", status_q.size(), 0);
      check("pop_queue_drained", pop_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_data_buffer
